// File: rtl/grid_game_pkg.sv
// Shared encodings for the grid game controller: cell marks, error and winner codes, FSM states.
package grid_game_pkg;

    localparam logic [1:0] CELL_EMPTY    = 2'b00;
    localparam logic [1:0] CELL_PLAYER   = 2'b01;
    localparam logic [1:0] CELL_COMPUTER = 2'b10;

    localparam logic [1:0] ERR_OCCUPIED  = 2'b00;
    localparam logic [1:0] ERR_RANGE     = 2'b01;
    localparam logic [1:0] ERR_TURN      = 2'b10;
    localparam logic [1:0] ERR_OVER      = 2'b11;

    localparam logic [1:0] WIN_NONE      = 2'b00;
    localparam logic [1:0] WIN_PLAYER    = 2'b01;
    localparam logic [1:0] WIN_COMPUTER  = 2'b10;
    localparam logic [1:0] WIN_DRAW      = 2'b11;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_CHECK = 2'd1;
    localparam state_t ST_OVER  = 2'd2;

    localparam logic [1:0] DIR_ROW  = 2'd0;
    localparam logic [1:0] DIR_COL  = 2'd1;
    localparam logic [1:0] DIR_DIAG = 2'd2;
    localparam logic [1:0] DIR_ANTI = 2'd3;

    // Run length never exceeds 2*WIN_LEN-1 = 15 for WIN_LEN <= 8
    localparam int unsigned RUN_W = 4;

    function automatic int unsigned min1_clog2(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic [1:0] mark_of(input logic who);
        return who ? CELL_COMPUTER : CELL_PLAYER;
    endfunction

endpackage

// File: rtl/grid_game_line_count.sv
// Combinational run-length counter through one cell along one direction.
module grid_line_count
    import grid_game_pkg::*;
#(
    parameter  int unsigned N       = 3,
    parameter  int unsigned WIN_LEN = 3,
    localparam int unsigned CW      = min1_clog2(N),
    localparam int unsigned CELLS   = N * N,
    localparam int unsigned IW      = min1_clog2(CELLS)
) (
    input  logic [CELLS-1:0][1:0] board,
    input  logic [CW-1:0]         origin_row,
    input  logic [CW-1:0]         origin_col,
    input  logic [1:0]            direction,
    output logic [RUN_W-1:0]      run_len
);

    int            dr;
    int            dc;
    int            r;
    int            c;
    int            total;
    logic          open;
    logic [1:0]    mark;
    logic [IW-1:0] idx;

    // Walk each side of the origin up to WIN_LEN-1 cells, stopping at a mismatch or the edge
    always_comb begin
        dr    = 0;
        dc    = 1;
        r     = 0;
        c     = 0;
        total = 1;
        open  = 1'b0;
        idx   = '0;
        case (direction)
            DIR_COL:  begin dr = 1; dc = 0;  end
            DIR_DIAG: begin dr = 1; dc = 1;  end
            DIR_ANTI: begin dr = 1; dc = -1; end
            default:  begin dr = 0; dc = 1;  end
        endcase
        mark = board[IW'(int'(origin_row) * int'(N) + int'(origin_col))];
        for (int s = 0; s < 2; s++) begin
            open = 1'b1;
            for (int k = 1; k < int'(WIN_LEN); k++) begin
                r = int'(origin_row) + ((s == 0) ? k : -k) * dr;
                c = int'(origin_col) + ((s == 0) ? k : -k) * dc;
                if (r < 0 || r >= int'(N) || c < 0 || c >= int'(N)) begin
                    open = 1'b0;
                end else begin
                    idx = IW'(r * int'(N) + c);
                    if (open && board[idx] == mark) begin
                        total = total + 1;
                    end else begin
                        open = 1'b0;
                    end
                end
            end
        end
        run_len = RUN_W'(total);
    end

endmodule

// File: rtl/grid_game_ctrl.sv
// Two-party grid game referee: validates moves, stores the board, detects wins and draws.
module grid_game_ctrl
    import grid_game_pkg::*;
#(
    parameter  int unsigned N       = 3,
    parameter  int unsigned WIN_LEN = 3,
    parameter  int unsigned FIRST   = 0,
    localparam int unsigned CW      = min1_clog2(N),
    localparam int unsigned CELLS   = N * N,
    localparam int unsigned IW      = min1_clog2(CELLS),
    localparam int unsigned MCW     = $clog2(CELLS + 1)
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           new_game,
    input  logic           move_valid,
    output logic           move_ready,
    input  logic           move_who,
    input  logic [CW-1:0]  move_row,
    input  logic [CW-1:0]  move_col,
    output logic           move_done,
    output logic           move_err,
    output logic [1:0]     err_code,
    input  logic [CW-1:0]  rd_row,
    input  logic [CW-1:0]  rd_col,
    output logic [1:0]     rd_cell,
    output logic           turn,
    output logic           game_over,
    output logic [1:0]     winner,
    output logic [MCW-1:0] move_count
);

    state_t               state, state_n;
    logic [CELLS-1:0][1:0] board, board_n;
    logic [CW-1:0]        last_row, last_row_n;
    logic [CW-1:0]        last_col, last_col_n;
    logic [1:0]           dir, dir_n;
    logic                 win_seen, win_seen_n;
    logic                 turn_n, move_ready_n, game_over_n, move_done_n, move_err_n;
    logic [1:0]           err_code_n, rd_cell_n, winner_n;
    logic [MCW-1:0]       move_count_n;

    logic                 handshake, move_in_range, rd_in_range, line_win, won_now, board_full;
    logic [IW-1:0]        move_idx, rd_idx;
    logic [RUN_W-1:0]     run_len;

    grid_line_count #(
        .N       (N),
        .WIN_LEN (WIN_LEN)
    ) u_line_count (
        .board      (board),
        .origin_row (last_row),
        .origin_col (last_col),
        .direction  (dir),
        .run_len    (run_len)
    );

    assign handshake     = move_valid && move_ready;
    assign move_in_range = (32'(move_row) < N) && (32'(move_col) < N);
    assign rd_in_range   = (32'(rd_row) < N) && (32'(rd_col) < N);
    assign move_idx      = IW'(32'(move_row) * N + 32'(move_col));
    assign rd_idx        = IW'(32'(rd_row) * N + 32'(rd_col));
    assign line_win      = 32'(run_len) >= WIN_LEN;
    assign won_now       = win_seen || line_win;
    assign board_full    = 32'(move_count) == CELLS;

    // State and output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            board      <= '0;
            last_row   <= '0;
            last_col   <= '0;
            dir        <= DIR_ROW;
            win_seen   <= 1'b0;
            turn       <= 1'(FIRST);
            move_ready <= 1'b1;
            game_over  <= 1'b0;
            move_done  <= 1'b0;
            move_err   <= 1'b0;
            err_code   <= ERR_OCCUPIED;
            rd_cell    <= CELL_EMPTY;
            winner     <= WIN_NONE;
            move_count <= '0;
        end else begin
            state      <= state_n;
            board      <= board_n;
            last_row   <= last_row_n;
            last_col   <= last_col_n;
            dir        <= dir_n;
            win_seen   <= win_seen_n;
            turn       <= turn_n;
            move_ready <= move_ready_n;
            game_over  <= game_over_n;
            move_done  <= move_done_n;
            move_err   <= move_err_n;
            err_code   <= err_code_n;
            rd_cell    <= rd_cell_n;
            winner     <= winner_n;
            move_count <= move_count_n;
        end
    end

    // Next-state: move validation, one direction per CHECK cycle, outcome on leaving CHECK
    always_comb begin
        state_n      = state;
        board_n      = board;
        last_row_n   = last_row;
        last_col_n   = last_col;
        dir_n        = dir;
        win_seen_n   = win_seen;
        turn_n       = turn;
        winner_n     = winner;
        move_count_n = move_count;
        move_done_n  = 1'b0;
        move_err_n   = 1'b0;
        err_code_n   = err_code;
        rd_cell_n    = rd_in_range ? board[rd_idx] : CELL_EMPTY;

        if (new_game) begin
            state_n      = ST_IDLE;
            board_n      = '0;
            dir_n        = DIR_ROW;
            win_seen_n   = 1'b0;
            turn_n       = 1'(FIRST);
            winner_n     = WIN_NONE;
            move_count_n = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (handshake) begin
                        if (!move_in_range) begin
                            move_err_n = 1'b1;
                            err_code_n = ERR_RANGE;
                        end else if (move_who != turn) begin
                            move_err_n = 1'b1;
                            err_code_n = ERR_TURN;
                        end else if (board[move_idx] != CELL_EMPTY) begin
                            move_err_n = 1'b1;
                            err_code_n = ERR_OCCUPIED;
                        end else begin
                            board_n[move_idx] = mark_of(move_who);
                            move_count_n      = move_count + MCW'(1);
                            last_row_n        = move_row;
                            last_col_n        = move_col;
                            dir_n             = DIR_ROW;
                            win_seen_n        = 1'b0;
                            state_n           = ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    win_seen_n = won_now;
                    dir_n      = dir + 2'd1;
                    if (dir == DIR_ANTI) begin
                        move_done_n = 1'b1;
                        if (won_now) begin
                            state_n  = ST_OVER;
                            winner_n = turn ? WIN_COMPUTER : WIN_PLAYER;
                        end else if (board_full) begin
                            state_n  = ST_OVER;
                            winner_n = WIN_DRAW;
                        end else begin
                            state_n = ST_IDLE;
                            turn_n  = ~turn;
                        end
                    end
                end
                ST_OVER: begin
                    if (handshake) begin
                        move_err_n = 1'b1;
                        err_code_n = ERR_OVER;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end

        move_ready_n = (state_n != ST_CHECK);
        game_over_n  = (state_n == ST_OVER);
    end

endmodule

// File: tb/tb_grid_game_ctrl.sv
// Bench for grid_game_ctrl: directed scenarios plus random games against a line-scanning board model.
module tb_grid_game_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       new_game, move_valid, move_who, sel;
    logic [2:0] move_row, move_col, rd_row, rd_col;

    logic       ready_a, done_a, err_a, turn_a, over_a;
    logic [1:0] code_a, cell_a, win_a;
    logic [3:0] cnt_a;
    logic       ready_b, done_b, err_b, turn_b, over_b;
    logic [1:0] code_b, cell_b, win_b;
    logic [4:0] cnt_b;

    logic       o_ready, o_done, o_err, o_turn, o_over;
    logic [1:0] o_code, o_cell, o_win;
    logic [4:0] o_cnt;

    always #5 clock = ~clock;

    grid_game_ctrl #(.N(3), .WIN_LEN(3), .FIRST(0)) dut_a (
        .clock(clock), .reset(reset), .new_game(new_game),
        .move_valid(move_valid & ~sel), .move_ready(ready_a), .move_who(move_who),
        .move_row(move_row[1:0]), .move_col(move_col[1:0]),
        .move_done(done_a), .move_err(err_a), .err_code(code_a),
        .rd_row(rd_row[1:0]), .rd_col(rd_col[1:0]), .rd_cell(cell_a),
        .turn(turn_a), .game_over(over_a), .winner(win_a), .move_count(cnt_a)
    );

    grid_game_ctrl #(.N(5), .WIN_LEN(4), .FIRST(0)) dut_b (
        .clock(clock), .reset(reset), .new_game(new_game),
        .move_valid(move_valid & sel), .move_ready(ready_b), .move_who(move_who),
        .move_row(move_row), .move_col(move_col),
        .move_done(done_b), .move_err(err_b), .err_code(code_b),
        .rd_row(rd_row), .rd_col(rd_col), .rd_cell(cell_b),
        .turn(turn_b), .game_over(over_b), .winner(win_b), .move_count(cnt_b)
    );

    assign o_ready = sel ? ready_b : ready_a;
    assign o_done  = sel ? done_b  : done_a;
    assign o_err   = sel ? err_b   : err_a;
    assign o_turn  = sel ? turn_b  : turn_a;
    assign o_over  = sel ? over_b  : over_a;
    assign o_code  = sel ? code_b  : code_a;
    assign o_cell  = sel ? cell_b  : cell_a;
    assign o_win   = sel ? win_b   : win_a;
    assign o_cnt   = sel ? cnt_b   : {1'b0, cnt_a};

    // Reference model: board of 0/1/2, game result found by scanning every window of WIN_LEN cells
    int mN, mW;
    int mb [0:7][0:7];
    int m_turn, m_cnt, m_win;
    bit m_over;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    function automatic void m_clear();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                mb[r][c] = 0;
        m_turn = 0;
        m_cnt  = 0;
        m_win  = 0;
        m_over = 1'b0;
    endfunction

    function automatic bit m_line(input int who);
        int dr [4] = '{0, 1, 1, 1};
        int dc [4] = '{1, 0, 1, -1};
        for (int r = 0; r < mN; r++)
            for (int c = 0; c < mN; c++)
                for (int d = 0; d < 4; d++) begin
                    bit ok = 1'b1;
                    for (int k = 0; k < mW; k++) begin
                        int rr = r + k * dr[d];
                        int cc = c + k * dc[d];
                        if (rr < 0 || rr >= mN || cc < 0 || cc >= mN) ok = 1'b0;
                        else if (mb[rr][cc] != who + 1) ok = 1'b0;
                    end
                    if (ok) return 1'b1;
                end
        return 1'b0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic play(input int who, input int r, input int c);
        bit exp_err;
        int exp_code;
        int lat;
        exp_err  = 1'b1;
        exp_code = 0;
        if (m_over)                     exp_code = 3;
        else if (r >= mN || c >= mN)    exp_code = 1;
        else if (who != m_turn)         exp_code = 2;
        else if (mb[r][c] != 0)         exp_code = 0;
        else                            exp_err  = 1'b0;

        @(negedge clock);
        move_valid = 1'b1;
        move_who   = 1'(who);
        move_row   = 3'(r);
        move_col   = 3'(c);
        @(negedge clock);
        move_valid = 1'b0;
        check("move_err", 32'(o_err), 32'(exp_err));
        check("ready_after_move", 32'(o_ready), 32'(exp_err));
        if (exp_err) begin
            check("err_code", 32'(o_code), exp_code);
            @(negedge clock);
            check("err_single_pulse", 32'(o_err), 0);
        end else begin
            mb[r][c] = who + 1;
            m_cnt++;
            if (m_line(who)) begin
                m_over = 1'b1;
                m_win  = who + 1;
            end else if (m_cnt == mN * mN) begin
                m_over = 1'b1;
                m_win  = 3;
            end else begin
                m_turn = 1 - m_turn;
            end
            lat = 0;
            for (int k = 1; k <= 10 && lat == 0; k++) begin
                @(negedge clock);
                if (o_done === 1'b1) lat = k;
            end
            check("done_latency", lat, 4);
            check("err_with_done", 32'(o_err), 0);
            check("winner", 32'(o_win), m_win);
            check("game_over", 32'(o_over), 32'(m_over));
            check("turn", 32'(o_turn), m_turn);
            check("move_count", 32'(o_cnt), m_cnt);
            @(negedge clock);
            check("done_single_pulse", 32'(o_done), 0);
        end
    endtask

    task automatic read_check(input int r, input int c);
        int e;
        @(negedge clock);
        rd_row = 3'(r);
        rd_col = 3'(c);
        @(negedge clock);
        e = (r < mN && c < mN) ? mb[r][c] : 0;
        check("rd_cell", 32'(o_cell), e);
    endtask

    task automatic start_game();
        @(negedge clock);
        new_game = 1'b1;
        @(negedge clock);
        new_game = 1'b0;
        m_clear();
        check("ng_ready", 32'(o_ready), 1);
        check("ng_count", 32'(o_cnt), 0);
        check("ng_turn", 32'(o_turn), 0);
        check("ng_winner", 32'(o_win), 0);
        check("ng_over", 32'(o_over), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        bit done_seen;
        reset = 1'b1; new_game = 1'b0; move_valid = 1'b0; move_who = 1'b0;
        move_row = '0; move_col = '0; rd_row = '0; rd_col = '0; sel = 1'b0;
        mN = 3; mW = 3;
        m_clear();
        repeat (3) @(negedge clock);
        reset = 1'b0;

        // Reset values
        check("rst_ready", 32'(o_ready), 1);
        check("rst_over", 32'(o_over), 0);
        check("rst_winner", 32'(o_win), 0);
        check("rst_count", 32'(o_cnt), 0);
        check("rst_turn", 32'(o_turn), 0);
        check("rst_done", 32'(o_done), 0);
        check("rst_err", 32'(o_err), 0);
        check("rst_code", 32'(o_code), 0);
        check("rst_cell", 32'(o_cell), 0);

        // Player wins the top row
        start_game();
        play(0, 0, 0); play(1, 1, 0); play(0, 0, 1); play(1, 1, 1); play(0, 0, 2);
        check("row_win_winner", 32'(o_win), 1);
        check("row_win_over", 32'(o_over), 1);
        check("row_win_count", 32'(o_cnt), 5);
        read_check(0, 2); read_check(1, 1); read_check(2, 2); read_check(3, 0);

        // Rejections: occupied, out of range, wrong turn
        start_game();
        play(0, 0, 0);
        play(1, 0, 0);
        check("occupied_code", 32'(o_code), 0);
        play(1, 3, 0);
        play(0, 1, 1);
        check("count_after_rejects", 32'(o_cnt), 1);

        // Nine-move draw, then a move after the game ended
        start_game();
        play(0, 0, 0); play(1, 0, 1); play(0, 0, 2); play(1, 1, 1); play(0, 1, 0);
        play(1, 1, 2); play(0, 2, 1); play(1, 2, 0); play(0, 2, 2);
        check("draw_winner", 32'(o_win), 3);
        check("draw_count", 32'(o_cnt), 9);
        play(1, 0, 0);
        check("over_code", 32'(o_code), 3);

        // New game during the second CHECK cycle aborts the move
        start_game();
        @(negedge clock);
        move_valid = 1'b1; move_who = 1'b0; move_row = 3'd1; move_col = 3'd1;
        @(negedge clock);
        move_valid = 1'b0;
        check("abort_in_check", 32'(o_ready), 0);
        @(negedge clock);
        new_game = 1'b1;
        @(negedge clock);
        new_game = 1'b0;
        m_clear();
        check("abort_ready", 32'(o_ready), 1);
        check("abort_turn", 32'(o_turn), 0);
        check("abort_count", 32'(o_cnt), 0);
        done_seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (o_done === 1'b1) done_seen = 1'b1;
            @(negedge clock);
        end
        check("abort_no_done", 32'(done_seen), 0);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                read_check(r, c);

        // Asynchronous reset in the middle of a CHECK
        start_game();
        play(0, 1, 1); play(1, 0, 0); play(1, 2, 2);
        read_check(1, 1);
        @(negedge clock);
        move_valid = 1'b1; move_who = 1'b0; move_row = 3'd2; move_col = 3'd2;
        @(negedge clock);
        move_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("arst_ready", 32'(o_ready), 1);
        check("arst_over", 32'(o_over), 0);
        check("arst_winner", 32'(o_win), 0);
        check("arst_count", 32'(o_cnt), 0);
        check("arst_turn", 32'(o_turn), 0);
        check("arst_done", 32'(o_done), 0);
        check("arst_err", 32'(o_err), 0);
        check("arst_code", 32'(o_code), 0);
        check("arst_cell", 32'(o_cell), 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        m_clear();
        done_seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            if (o_done === 1'b1) done_seen = 1'b1;
        end
        check("arst_no_done", 32'(done_seen), 0);
        read_check(1, 1);

        // 5x5 board, four in a row: computer builds the anti-diagonal
        @(negedge clock);
        sel = 1'b1; mN = 5; mW = 4;
        start_game();
        play(0, 0, 0); play(1, 0, 3); play(0, 4, 4); play(1, 1, 2);
        play(0, 4, 1); play(1, 2, 1);
        check("three_no_win", 32'(o_win), 0);
        play(0, 2, 4); play(1, 3, 0);
        check("anti_diag_winner", 32'(o_win), 2);
        read_check(3, 0); read_check(6, 1);

        // Random games on both boards
        for (int b = 0; b < 2; b++) begin
            @(negedge clock);
            sel = 1'(b);
            mN  = (b == 0) ? 3 : 5;
            mW  = (b == 0) ? 3 : 4;
            for (int g = 0; g < 4; g++) begin
                start_game();
                for (int m = 0; m < 60 && !m_over; m++) begin
                    int who = ($urandom_range(0, 4) == 0) ? 1 - m_turn : m_turn;
                    play(who, $urandom_range(0, mN), $urandom_range(0, mN));
                    if ($urandom_range(0, 3) == 0)
                        read_check($urandom_range(0, mN), $urandom_range(0, mN));
                end
                if (m_over) play(m_turn, 0, 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/grid_game_ctrl.md
GRID_GAME_CTRL -- requirements
Module: grid_game_ctrl

Interface
REQ-001 SHALL have parameter N, default 3, meaning board side length (range 3..8).
REQ-002 SHALL have parameter WIN_LEN, default 3, meaning contiguous marks needed to win (range 3..N).
REQ-003 SHALL have parameter FIRST, default 0, meaning first mover (0 player, 1 computer).
REQ-004 SHALL have clock  in  1  rising-edge clock.
REQ-005 SHALL have reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have new_game  in  1  synchronous board clear and restart.
REQ-007 SHALL have move_valid  in  1  move request.
REQ-008 SHALL have move_ready  out  1  block accepts a move.
REQ-009 SHALL have move_who  in  1  mover (0 player, 1 computer).
REQ-010 SHALL have move_row, move_col  in  CW each  target cell, where CW is clog2(N) with a minimum of 1.
REQ-011 SHALL have move_done  out  1  one-cycle pulse when an accepted move is fully evaluated.
REQ-012 SHALL have move_err  out  1  one-cycle pulse when a move is rejected.
REQ-013 SHALL have err_code  out  2  00 occupied, 01 out of range, 10 wrong turn, 11 game over; valid with move_err.
REQ-014 SHALL have rd_row, rd_col  in  CW each  board read address.
REQ-015 SHALL have rd_cell  out  2  registered cell contents: 00 empty, 01 player, 10 computer.
REQ-016 SHALL have turn  out  1  next expected mover.
REQ-017 SHALL have game_over  out  1  game finished.
REQ-018 SHALL have winner  out  2  00 none, 01 player, 10 computer, 11 draw.
REQ-019 SHALL have move_count  out  clog2(N*N+1) bits  accepted moves this game.

Function
REQ-020 SHALL use FSM states IDLE, CHECK, OVER; move_ready is 1 in IDLE and OVER and 0 in CHECK.
REQ-021 SHALL treat a handshake (move_valid && move_ready) in IDLE as a legal move when row<N, col<N, move_who==turn and the cell is empty.
REQ-022 SHALL apply rejection priority out-of-range > wrong turn > occupied; a rejection pulses move_err on the next cycle, leaves the board and count unchanged, and stays in IDLE.
REQ-023 SHALL answer any handshake in OVER with move_err and err_code 11.
REQ-024 SHALL, on a legal move, write the cell at the handshake edge, increment move_count, and enter CHECK.
REQ-025 SHALL have CHECK last exactly 4 cycles, evaluating one direction per cycle (row, column, diagonal, anti-diagonal) through the last cell.
REQ-026 SHALL, per direction, count contiguous equal marks on both sides of the last cell (at most WIN_LEN-1 each side, clipped at board edges); a total of 1 plus both sides >= WIN_LEN is a win.
REQ-027 SHALL, on leaving CHECK, pulse move_done once, then apply exactly one outcome: win -> OVER with winner set to the mover; else move_count==N*N -> OVER with winner 11; else IDLE with turn toggled.
REQ-028 SHALL hold game_over=1 exactly while in OVER.
REQ-029 SHALL make new_game take priority in every state: the next edge clears all cells, move_count, and winner; sets turn=FIRST; enters IDLE; and suppresses any pending move_done or move_err.
REQ-030 SHALL return rd_cell one cycle after the address, and return 00 for out-of-range addresses.
REQ-031 SHALL never let move_done and move_err both be high in the same cycle.

Reset
REQ-032 SHALL, on reset, clear all cells to 00, move_count to 0, winner to 00, game_over/move_done/move_err to 0, err_code to 00, and rd_cell to 00; set turn=FIRST; and enter state IDLE.
REQ-033 SHALL abandon any CHECK in progress when reset is asserted, producing no move_done.

Structure
REQ-034 SHALL place cell encoding, err_code values, winner codes and the FSM state type in shared package grid_game_pkg.
REQ-035 SHALL implement per-direction counting in one sub-module, grid_line_count, with inputs board, origin and direction, and output the run length.

Verification
REQ-036 SHALL cover, with N=3: player moves (0,0),(0,1),(0,2) interleaved with computer moves (1,0),(1,1) -> move_done after each, winner=01, game_over=1, move_count=5.
REQ-037 SHALL cover, with N=3: player (0,0), then computer (0,0) -> move_err with err_code 00; then computer with row=3 -> err_code 01; then player again -> err_code 10.
REQ-038 SHALL cover, with N=3: a 9-move draw sequence -> winner=11, move_count=9, and a 10th move gives err_code 11.
REQ-039 SHALL cover, with N=5 and WIN_LEN=4: computer completes anti-diagonal (0,3),(1,2),(2,1),(3,0) -> winner=10; with 3 in a row only -> no win.
REQ-040 SHALL cover: new_game asserted during the 2nd CHECK cycle -> no move_done, all rd_cell 00, turn=FIRST, and move_ready=1 on the next cycle.
REQ-041 SHALL cover: reset asserted mid-game -> all outputs at their reset values immediately, without waiting for a clock edge.
